intersectie_ctrl: RTL and testbench

//  Intersection scheduler above the per-approach light sequencers (modulE and its N/S/W siblings).

---
 rtl/semafor_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/intersectie_ctrl.sv | 121 ++++++++++++
 tb/tb_intersectie_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/semafor_pkg.sv
// Shared types and default timing constants for the intersection scheduler.
package semafor_pkg;

  typedef enum logic [2:0] {IDLE, ALL_RED, START, WAIT_DONE, MAINT} state_e;

  localparam logic [23:0] SEC_DEFAULT        = 24'd10000000;
  localparam int unsigned NUM_DIR_DEFAULT    = 4;
  localparam int unsigned T_ROSU_ALL_DEFAULT = 1;
  localparam int unsigned T_WD_DEFAULT       = 20;
  localparam logic [7:0]  SEC_CNT_MAX        = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching ptr+1, ptr+2, ... modulo NUM_DIR.
module rr_arbiter #(
  parameter int unsigned NUM_DIR = 4,
  localparam int unsigned W = $clog2(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] req,
  input  logic [W-1:0]       ptr,
  output logic [W-1:0]       gnt_idx,
  output logic               gnt_valid
);

  logic [W-1:0] cand;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    for (int unsigned i = NUM_DIR; i >= 1; i--) begin
      cand = W'((32'(ptr) + i) % NUM_DIR);
      if (req[cand]) begin
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intersectie_ctrl.sv
// Intersection scheduler: round-robin green grants with all-red clearance, a done watchdog
// and blinking-yellow maintenance mode.
module intersectie_ctrl
  import semafor_pkg::*;
#(
  parameter logic [23:0] SEC        = SEC_DEFAULT,
  parameter int unsigned NUM_DIR    = NUM_DIR_DEFAULT,
  parameter int unsigned T_ROSU_ALL = T_ROSU_ALL_DEFAULT,
  parameter int unsigned T_WD       = T_WD_DEFAULT,
  localparam int unsigned W = $clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               intretinere,
  input  logic [NUM_DIR-1:0] cerere,
  input  logic [NUM_DIR-1:0] done_dir,
  output logic [NUM_DIR-1:0] start_dir,
  output logic [W-1:0]       activ,
  output logic               galben_intermitent,
  output logic               eroare
);

  state_e       state;
  logic [23:0]  prescaler;
  logic [7:0]   sec_cnt;
  logic [W-1:0] ptr;
  logic         tick;
  logic [W-1:0] gnt_idx;
  logic         gnt_valid;

  assign tick = (prescaler == SEC - 24'd1);

  rr_arbiter #(
    .NUM_DIR(NUM_DIR)
  ) u_rr_arbiter (
    .req      (cerere),
    .ptr      (ptr),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  // Every state change also clears prescaler and sec_cnt (later NBAs override the defaults).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      ptr                <= W'(NUM_DIR - 1);
      prescaler          <= '0;
      sec_cnt            <= '0;
      start_dir          <= '0;
      activ              <= '0;
      galben_intermitent <= 1'b0;
      eroare             <= 1'b0;
    end else begin
      start_dir <= '0;
      prescaler <= tick ? '0 : prescaler + 24'd1;
      if (tick && sec_cnt != SEC_CNT_MAX) sec_cnt <= sec_cnt + 8'd1;

      if (intretinere && state != MAINT) begin
        state     <= MAINT;
        prescaler <= '0;
        sec_cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (|cerere) begin
              state     <= ALL_RED;
              prescaler <= '0;
              sec_cnt   <= '0;
            end
          end
          ALL_RED: begin
            if (tick && sec_cnt == 8'(T_ROSU_ALL - 1)) begin
              prescaler <= '0;
              sec_cnt   <= '0;
              if (gnt_valid) begin
                state     <= START;
                start_dir <= {{(NUM_DIR - 1){1'b0}}, 1'b1} << gnt_idx;
                activ     <= gnt_idx;
                ptr       <= gnt_idx;
              end else begin
                state <= IDLE;
              end
            end
          end
          START: begin
            state     <= WAIT_DONE;
            prescaler <= '0;
            sec_cnt   <= '0;
          end
          WAIT_DONE: begin
            // done is checked first so it wins a tie with the final watchdog tick
            if (done_dir[activ]) begin
              state     <= ALL_RED;
              prescaler <= '0;
              sec_cnt   <= '0;
            end else if (tick && sec_cnt == 8'(T_WD - 1)) begin
              eroare    <= 1'b1;
              state     <= MAINT;
              prescaler <= '0;
              sec_cnt   <= '0;
            end
          end
          MAINT: begin
            if (!intretinere && !eroare) begin
              state              <= ALL_RED;
              galben_intermitent <= 1'b0;
              prescaler          <= '0;
              sec_cnt            <= '0;
            end else if (tick) begin
              galben_intermitent <= ~galben_intermitent;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_intersectie_ctrl.sv
// Self-checking bench: arbiter vector table, directed scenarios and randomized traffic
// compared every cycle against an elapsed-time reference model.
module tb_intersectie_ctrl;

  localparam int SEC_T  = 4;
  localparam int ND     = 4;
  localparam int T_RA   = 1;
  localparam int T_WD_T = 20;
  localparam int DLY    = 10;
  localparam int GAP    = DLY + 1 + T_RA * SEC_T;

  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_START = 2;
  localparam int P_WAIT  = 3;
  localparam int P_MAINT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       intretinere;
  logic [3:0] cerere;
  logic [3:0] done_dir;
  logic [3:0] start_dir;
  logic [1:0] activ;
  logic       galben_intermitent;
  logic       eroare;

  logic [3:0] arb_req;
  logic [1:0] arb_ptr;
  logic [1:0] arb_idx;
  logic       arb_valid;

  int n_checks = 0;
  int n_err    = 0;
  int edge_n   = 0;
  int since    = 1000;

  // Reference model state
  int         m_phase;
  int         m_n;
  int         m_last;
  logic [1:0] m_activ;
  logic [3:0] m_start;
  logic       m_blink;
  logic       m_err;

  logic [3:0] pulse_q[$];
  logic [1:0] pulse_a[$];
  int         pulse_t[$];
  int         tog_t[$];

  typedef struct {
    logic [3:0] req;
    logic [1:0] ptr;
    logic [1:0] idx;
    logic       valid;
  } arb_vec_t;

  typedef struct {
    logic [3:0] start;
    logic [1:0] act;
  } grant_t;

  arb_vec_t arb_tab[12];
  grant_t   rr_tab[5];

  int         t_start, t_err, cur_dly;
  logic       prev_g, ri;
  logic [3:0] rc, rd;

  always #5 clk = ~clk;

  intersectie_ctrl #(
    .SEC       (24'(SEC_T)),
    .NUM_DIR   (ND),
    .T_ROSU_ALL(T_RA),
    .T_WD      (T_WD_T)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .intretinere       (intretinere),
    .cerere            (cerere),
    .done_dir          (done_dir),
    .start_dir         (start_dir),
    .activ             (activ),
    .galben_intermitent(galben_intermitent),
    .eroare            (eroare)
  );

  rr_arbiter #(
    .NUM_DIR(ND)
  ) u_arb (
    .req      (arb_req),
    .ptr      (arb_ptr),
    .gnt_idx  (arb_idx),
    .gnt_valid(arb_valid)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic int rr_pick(input logic [3:0] c, input int last);
    for (int i = 1; i <= ND; i++) begin
      if (c[(last + i) % ND]) return (last + i) % ND;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_phase = P_IDLE;
    m_n     = 0;
    m_last  = ND - 1;
    m_activ = '0;
    m_start = '0;
    m_blink = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic void enter(input int p);
    m_phase = p;
    m_n     = 0;
  endfunction

  // n = cycles spent in the current phase including the one that just ended.
  function automatic void model_step(input logic i, input logic [3:0] c, input logic [3:0] d);
    int n;
    int pick;
    n       = m_n + 1;
    m_n     = n;
    m_start = '0;
    if (i && m_phase != P_MAINT) begin
      enter(P_MAINT);
    end else begin
      case (m_phase)
        P_IDLE: if (c != 0) enter(P_CLEAR);
        P_CLEAR: begin
          if (n == T_RA * SEC_T) begin
            pick = rr_pick(c, m_last);
            if (pick >= 0) begin
              m_last  = pick;
              m_activ = 2'(pick);
              m_start = 4'(1 << pick);
              enter(P_START);
            end else begin
              enter(P_IDLE);
            end
          end
        end
        P_START: enter(P_WAIT);
        P_WAIT: begin
          if (d[m_activ]) enter(P_CLEAR);
          else if (n == T_WD_T * SEC_T) begin
            m_err = 1'b1;
            enter(P_MAINT);
          end
        end
        default: begin
          if (!i && !m_err) begin
            m_blink = 1'b0;
            enter(P_CLEAR);
          end else if (n % SEC_T == 0) begin
            m_blink = ~m_blink;
          end
        end
      endcase
    end
  endfunction

  function automatic void clear_log();
    pulse_q.delete();
    pulse_a.delete();
    pulse_t.delete();
  endfunction

  function automatic logic [3:0] pq(input int k);
    if (k < pulse_q.size()) return pulse_q[k];
    return 4'bxxxx;
  endfunction

  task automatic cycle(input logic i, input logic [3:0] c, input logic [3:0] d);
    intretinere = i;
    cerere      = c;
    done_dir    = d;
    @(posedge clk);
    model_step(i, c, d);
    edge_n++;
    if (m_start != 0) since = 0;
    else since++;
    #1;
    check("outputs", {24'd0, start_dir, activ, galben_intermitent, eroare},
          {24'd0, m_start, m_activ, m_blink, m_err});
    if (start_dir != 0) begin
      pulse_q.push_back(start_dir);
      pulse_a.push_back(activ);
      pulse_t.push_back(edge_n);
    end
  endtask

  // Emulates a sequencer that answers done dly cycles after its start pulse (dly<0: never).
  task automatic run(input int n, input logic [3:0] c, input int dly, input logic i);
    logic [3:0] d;
    for (int k = 0; k < n; k++) begin
      d = '0;
      if (m_phase == P_WAIT && since == dly) d[m_activ] = 1'b1;
      cycle(i, c, d);
    end
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    model_reset();
    #1;
    check("async_reset", {28'd0, start_dir, activ, galben_intermitent, eroare}, 32'd0);
    intretinere = 1'b0;
    cerere      = '0;
    done_dir    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    since = 1000;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

  initial begin
    arb_tab[0]  = '{4'b1111, 2'd3, 2'd0, 1'b1};
    arb_tab[1]  = '{4'b1111, 2'd0, 2'd1, 1'b1};
    arb_tab[2]  = '{4'b1111, 2'd1, 2'd2, 1'b1};
    arb_tab[3]  = '{4'b1111, 2'd2, 2'd3, 1'b1};
    arb_tab[4]  = '{4'b0100, 2'd2, 2'd2, 1'b1};
    arb_tab[5]  = '{4'b0001, 2'd0, 2'd0, 1'b1};
    arb_tab[6]  = '{4'b1000, 2'd3, 2'd3, 1'b1};
    arb_tab[7]  = '{4'b0101, 2'd2, 2'd0, 1'b1};
    arb_tab[8]  = '{4'b0011, 2'd0, 2'd1, 1'b1};
    arb_tab[9]  = '{4'b0000, 2'd1, 2'd0, 1'b0};
    arb_tab[10] = '{4'b1001, 2'd0, 2'd3, 1'b1};
    arb_tab[11] = '{4'b0110, 2'd3, 2'd1, 1'b1};
    rr_tab[0]   = '{4'b0001, 2'd0};
    rr_tab[1]   = '{4'b0010, 2'd1};
    rr_tab[2]   = '{4'b0100, 2'd2};
    rr_tab[3]   = '{4'b1000, 2'd3};
    rr_tab[4]   = '{4'b0001, 2'd0};

    reset = 1'b1;
    intretinere = 1'b0;
    cerere = '0;
    done_dir = '0;
    arb_req = '0;
    arb_ptr = '0;
    model_reset();
    #2;
    check("reset_hold", {28'd0, start_dir, activ, galben_intermitent, eroare}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle with no demand
    clear_log();
    run(24, 4'b0000, -1, 1'b0);
    check("idle_no_start", pulse_q.size(), 0);

    // Arbiter vector table
    foreach (arb_tab[k]) begin
      arb_req = arb_tab[k].req;
      arb_ptr = arb_tab[k].ptr;
      #1;
      check("arb_valid", arb_valid, arb_tab[k].valid);
      if (arb_tab[k].valid) check("arb_idx", arb_idx, arb_tab[k].idx);
    end

    // All approaches requesting: 0,1,2,3,0 with fixed spacing
    do_reset();
    clear_log();
    run(80, 4'b1111, DLY, 1'b0);
    check("rr_count_ok", pulse_q.size() >= 5, 1);
    for (int k = 0; k < 5 && k < pulse_q.size(); k++) begin
      check("rr_start", pulse_q[k], rr_tab[k].start);
      check("rr_activ", pulse_a[k], rr_tab[k].act);
      if (k > 0) check("rr_gap", pulse_t[k] - pulse_t[k-1], GAP);
    end

    // Single requester, then a second one appears mid-phase
    do_reset();
    clear_log();
    run(50, 4'b0100, DLY, 1'b0);
    check("single_count_ok", pulse_q.size() >= 3, 1);
    foreach (pulse_q[k]) begin
      check("single_start", pulse_q[k], 4'b0100);
      check("single_activ", pulse_a[k], 2'd2);
    end
    clear_log();
    run(20, 4'b0101, DLY, 1'b0);
    check("late_req_grant", pq(0), 4'b0001);

    // Watchdog: no done ever
    do_reset();
    clear_log();
    t_start = -1;
    t_err = -1;
    for (int k = 0; k < 200 && t_err < 0; k++) begin
      cycle(1'b0, 4'b0001, 4'b0000);
      if (start_dir != 0 && t_start < 0) t_start = edge_n;
      if (eroare && t_err < 0) t_err = edge_n;
    end
    check("wd_latency", t_err - t_start, T_WD_T * SEC_T + 1);
    tog_t.delete();
    prev_g = galben_intermitent;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 4'b0001, 4'b0000);
      if (galben_intermitent != prev_g) tog_t.push_back(edge_n);
      prev_g = galben_intermitent;
    end
    check("blink_count_ok", tog_t.size() >= 4, 1);
    for (int k = 1; k < 4 && k < tog_t.size(); k++) check("blink_gap", tog_t[k] - tog_t[k-1], SEC_T);
    clear_log();
    run(3, 4'b0001, -1, 1'b1);
    run(10, 4'b0001, -1, 1'b0);
    check("err_sticky", eroare, 1'b1);
    check("err_no_start", pulse_q.size(), 0);

    // Maintenance pulse during WAIT_DONE, then release
    do_reset();
    run(8, 4'b1111, -1, 1'b0);
    run(1, 4'b1111, -1, 1'b1);
    run(4, 4'b1111, -1, 1'b1);
    check("maint_blink", galben_intermitent, 1'b1);
    run(1, 4'b1111, -1, 1'b1);
    clear_log();
    run(1, 4'b1111, -1, 1'b0);
    check("maint_exit_clear", galben_intermitent, 1'b0);
    run(4, 4'b1111, -1, 1'b0);
    check("maint_regrant_n", pulse_q.size(), 1);
    check("maint_regrant", pq(0), 4'b0010);
    check("maint_regrant_t", pulse_t.size() > 0 ? pulse_t[0] : -1, edge_n);

    // Maintenance rising exactly when a grant would issue
    do_reset();
    run(4, 4'b1111, -1, 1'b0);
    run(1, 4'b1111, -1, 1'b1);
    check("intr_blocks_start", start_dir, 4'b0000);
    clear_log();
    run(5, 4'b1111, -1, 1'b0);
    check("intr_then_grant", pq(0), 4'b0001);

    // done on the final watchdog tick wins
    do_reset();
    clear_log();
    run(120, 4'b0001, T_WD_T * SEC_T, 1'b0);
    check("tie_no_error", eroare, 1'b0);
    check("tie_grants", pulse_q.size(), 2);

    // Async reset mid-WAIT_DONE, then first grant goes to 0
    do_reset();
    run(8, 4'b0100, -1, 1'b0);
    check("pre_reset_activ", activ, 2'd2);
    do_reset();
    clear_log();
    run(10, 4'b1111, -1, 1'b0);
    check("post_reset_grant", pq(0), 4'b0001);

    // Randomized traffic against the model
    do_reset();
    cur_dly = DLY;
    rc = 4'b1111;
    for (int k = 0; k < 1800; k++) begin
      if (k % 450 == 449) do_reset();
      if ($urandom_range(0, 4) == 0) rc = 4'($urandom_range(0, 15));
      ri = ($urandom_range(0, 99) < 2);
      rd = 4'($urandom_range(0, 15));
      rd[m_activ] = (m_phase == P_WAIT && since == cur_dly);
      cycle(ri, rc, rd);
      if (m_start != 0) cur_dly = $urandom_range(1, 85);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
